// File: rtl/fruit_ctrl.sv
// fruit_ctrl -- per-fruit game controller for the fruit motion generator.
//
// Once per frame it decides whether to launch a fruit, whether the blade sliced
// it, and whether the fruit was missed. It also keeps the slice count and the
// remaining lives.
//
// Optional feature macro: FRUIT_CTRL_LIVES_EN
//   defined   : a miss costs a life, and running out of lives enters GAMEOVER.
//   undefined : o_lives is tied to LIVES and o_game_over is tied to 0.
//               A miss simply relaunches the fruit.
//
// Ports
//   i_frame_clk    in   1   frame-rate clock; all state changes on its rising edge
//   i_reset_n      in   1   synchronous reset, active low
//   i_start        in   1   level; leaves IDLE/GAMEOVER when high
//   i_fruit_x/y    in  10   fruit centre (the generator's previous-frame position)
//   i_fruit_s      in  10   fruit half-size
//   i_blade_x/y    in  10   blade cursor
//   i_blade_down   in   1   blade pressed this frame
//   o_new_fruit    out  1   one-cycle pulse: generator loads a fresh launch
//   o_move_fruit   out  1   level: generator integrates motion
//   o_fruits_cut   out  8   slice count, saturating at 255
//   o_sliced       out  1   one-cycle pulse on a slice
//   o_show_split   out  1   high while the split sprite is shown
//   o_lives        out  2   remaining lives
//   o_game_over    out  1   high in GAMEOVER
module fruit_ctrl #(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int BLADE_R      = 4,
  parameter int LAUNCH_DELAY = 30,
  parameter int SLICE_HOLD   = 15,
  parameter int MIN_FLIGHT   = 8,
  parameter int LIVES        = 3
) (
  input  logic       i_frame_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [9:0] i_fruit_x,
  input  logic [9:0] i_fruit_y,
  input  logic [9:0] i_fruit_s,
  input  logic [9:0] i_blade_x,
  input  logic [9:0] i_blade_y,
  input  logic       i_blade_down,
  output logic       o_new_fruit,
  output logic       o_move_fruit,
  output logic [7:0] o_fruits_cut,
  output logic       o_sliced,
  output logic       o_show_split,
  output logic [1:0] o_lives,
  output logic       o_game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_FLIGHT,
    S_SLICED,
    S_GAMEOVER
  } state_t;

  localparam logic [7:0] LAUNCH_LAST = 8'(LAUNCH_DELAY - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(SLICE_HOLD - 1);
  localparam logic [7:0] FLIGHT_SAT  = 8'(MIN_FLIGHT);

  state_t     r_state;
  logic [7:0] r_timer;
  logic [7:0] r_count;
  logic       r_new_fruit;
  logic       r_move_fruit;
  logic       r_sliced;
  logic       r_show_split;
`ifdef FRUIT_CTRL_LIVES_EN
  logic [1:0] r_lives;
  logic       r_game_over;
`endif

  // The differences are formed at 11 bits, so a fruit near column 0 and a blade
  // near column 1023 cannot wrap into a false hit.
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic        [10:0] w_adx;
  logic        [10:0] w_ady;
  logic        [10:0] w_reach;
  logic               w_hit;
  logic               w_offscreen;
  logic               w_miss;

  assign w_dx    = $signed({1'b0, i_blade_x}) - $signed({1'b0, i_fruit_x});
  assign w_dy    = $signed({1'b0, i_blade_y}) - $signed({1'b0, i_fruit_y});
  assign w_adx   = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady   = w_dy[10] ? $unsigned(-w_dy) : $unsigned(w_dy);
  assign w_reach = {1'b0, i_fruit_s} + 11'(BLADE_R);
  assign w_hit   = i_blade_down && (w_adx <= w_reach) && (w_ady <= w_reach);

  // The fruit spawns at the bottom row (Y_MAX), so an off-screen position is
  // ignored until the flight timer has saturated.
  assign w_offscreen = (i_fruit_x > 10'(X_MAX)) || (i_fruit_y > 10'(Y_MAX));
  assign w_miss      = (r_timer == FLIGHT_SAT) && w_offscreen;

  always_ff @(posedge i_frame_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_count      <= '0;
      r_new_fruit  <= 1'b0;
      r_move_fruit <= 1'b0;
      r_sliced     <= 1'b0;
      r_show_split <= 1'b0;
`ifdef FRUIT_CTRL_LIVES_EN
      r_lives      <= 2'(LIVES);
      r_game_over  <= 1'b0;
`endif
    end else begin
      r_new_fruit <= 1'b0;
      r_sliced    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_LAUNCH;
            r_timer <= '0;
            r_count <= '0;
`ifdef FRUIT_CTRL_LIVES_EN
            r_lives <= 2'(LIVES);
`endif
          end
        end
        S_LAUNCH: begin
          if (r_timer == LAUNCH_LAST) begin
            r_new_fruit <= 1'b1;
            r_state     <= S_FLIGHT;
            r_timer     <= '0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_FLIGHT: begin
          r_move_fruit <= 1'b1;
          // A hit takes priority over a miss decided on the same frame.
          if (w_hit) begin
            r_state      <= S_SLICED;
            r_sliced     <= 1'b1;
            r_show_split <= 1'b1;
            r_timer      <= '0;
            if (r_count != 8'hFF) begin
              r_count <= r_count + 8'd1;
            end
          end else if (w_miss) begin
            r_move_fruit <= 1'b0;
            r_timer      <= '0;
`ifdef FRUIT_CTRL_LIVES_EN
            r_lives <= r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              r_state     <= S_GAMEOVER;
              r_game_over <= 1'b1;
            end else begin
              r_state <= S_LAUNCH;
            end
`else
            r_state <= S_LAUNCH;
`endif
          end else if (r_timer != FLIGHT_SAT) begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_SLICED: begin
          if (r_timer == HOLD_LAST) begin
            r_state      <= S_LAUNCH;
            r_show_split <= 1'b0;
            r_move_fruit <= 1'b0;
            r_timer      <= '0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_GAMEOVER: begin
          if (i_start) begin
            r_state <= S_LAUNCH;
            r_timer <= '0;
            r_count <= '0;
`ifdef FRUIT_CTRL_LIVES_EN
            r_lives     <= 2'(LIVES);
            r_game_over <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_new_fruit  = r_new_fruit;
  assign o_move_fruit = r_move_fruit;
  assign o_fruits_cut = r_count;
  assign o_sliced     = r_sliced;
  assign o_show_split = r_show_split;
`ifdef FRUIT_CTRL_LIVES_EN
  assign o_lives      = r_lives;
  assign o_game_over  = r_game_over;
`else
  assign o_lives      = 2'(LIVES);
  assign o_game_over  = 1'b0;
`endif

endmodule

// File: doc/fruit_ctrl.md
# fruit_ctrl

Per-fruit game controller driving the fruit motion generator's control inputs (new_fruit, move_fruit, number_of_fruits_cut). Consumes the generator's fruit position/size plus the blade cursor once per frame; decides launch, slice and miss; counts score and lives. Sits between the blade input path and the fruit motion block, clocked by the frame tick.

## Interface
- X_MAX, 639: rightmost on-screen column; fruitX above this is off-screen.
- Y_MAX, 479: bottom row; fruitY above this is off-screen (includes 10-bit wrap).
- BLADE_R, 4: blade hit radius added to fruit size.
- LAUNCH_DELAY, 30: frames between relaunch decision and new_fruit pulse.
- SLICE_HOLD, 15: frames the sliced fruit stays visible (split sprite) before relaunch.
- MIN_FLIGHT, 8: frames after launch during which off-screen is ignored (spawn row is Y_MAX).
- LIVES, 3: starting lives (1..3).
- frame_clk  in  1  frame-rate clock; all state changes on rising edge.
- Reset  in  1  synchronous reset, active-low.
- start  in  1  level; leaves IDLE/GAMEOVER when high.
- fruitX, fruitY  in  10 each  fruit centre, unsigned.
- fruitS  in  10  fruit half-size.
- bladeX, bladeY  in  10 each  blade cursor.
- blade_down  in  1  blade pressed (slicing) this frame.
- new_fruit  out  1  one-cycle pulse: generator loads fresh random launch.
- move_fruit  out  1  level: generator integrates motion.
- number_of_fruits_cut  out  8  slice count, saturates at 255.
- sliced  out  1  one-cycle pulse on slice (sound/score FX).
- show_split  out  1  high in SLICED; renderer draws split sprite.
- lives  out  2  remaining lives.
- game_over  out  1  high in GAMEOVER.

## Operation
- States: IDLE, LAUNCH, FLIGHT, SLICED, GAMEOVER.
- IDLE: all outputs at reset values; start=1 -> LAUNCH, timer cleared, lives=LIVES, count=0.
- LAUNCH: move_fruit=0; timer counts frames; at timer==LAUNCH_DELAY-1 assert new_fruit for that cycle and go FLIGHT (timer cleared).
- FLIGHT: move_fruit=1; timer increments, saturating at MIN_FLIGHT.
- Hit: blade_down && |bladeX-fruitX| <= fruitS+BLADE_R && |bladeY-fruitY| <= fruitS+BLADE_R; differences formed as 11-bit signed, magnitude compared against 11-bit sum (no wrap).
- Hit in FLIGHT -> SLICED, sliced pulse, count+1 (saturate 255). Hit checked from first FLIGHT cycle.
- Miss: timer==MIN_FLIGHT && (fruitX > X_MAX || fruitY > Y_MAX). Lives decrement; lives reaching 0 -> GAMEOVER, else -> LAUNCH.
- Hit and miss same cycle: hit wins, no life lost.
- SLICED: move_fruit=1 (halves keep falling), show_split=1; after SLICE_HOLD frames -> LAUNCH.
- GAMEOVER: move_fruit=0, game_over=1, count and lives held; start=1 -> LAUNCH with lives=LIVES, count=0.
- blade_down ignored outside FLIGHT.

## Timing
- Reset (Reset=0 at edge): state IDLE, new_fruit=0, move_fruit=0, count=0, sliced=0, show_split=0, lives=LIVES, game_over=0. Reset mid-flight takes priority over every transition.
- Outputs registered; decisions from inputs sampled at edge N appear after edge N.
- start -> first new_fruit: LAUNCH_DELAY cycles after the edge entering LAUNCH.
- new_fruit and move_fruit never both high.
- Hit sampled at edge N: sliced high cycle N+1 only; show_split high for exactly SLICE_HOLD cycles.
- Fruit inputs are the generator's previous-frame position; one-frame lag is accepted.

## Configuration
- FRUIT_CTRL_LIVES_EN defined: lives logic as above; misses decrement lives, GAMEOVER reachable.
- Undefined: lives output tied to LIVES, game_over tied 0, GAMEOVER unreachable; miss goes directly to LAUNCH.

## Test plan
- Reset=0 two cycles mid-FLIGHT -> all outputs at reset values, state IDLE, lives=3.
- start=1, LAUNCH_DELAY=30 -> new_fruit single pulse 30 cycles after entering LAUNCH, move_fruit rises next cycle.
- fruit (300,200) size 10, blade (314,200) down, BLADE_R=4 -> sliced pulse, count=1, show_split 15 cycles; blade (315,200) -> no hit.
- fruitY=1000 (wrapped) at FLIGHT timer 3 -> no miss; at timer 8 -> lives 3->2, back to LAUNCH.
- Three misses with LIVES_EN -> game_over=1, count held; without macro -> lives stay 3, relaunch.
- Hit and fruitX=650 same cycle -> SLICED, lives unchanged; 256 slices -> count stays 255.
